// File: rtl/lstm_seq_ctrl_pkg.sv
// lstm_pkg: shared definitions for the LSTM sequence controller and the
// lstm_cell that sits beside it in the parent.
//   - LSTM_DATA_WIDTH / LSTM_FRACT_WIDTH: default Q8.8 word format
//   - lstm_word_t: one fixed-point word at the default width
//   - lstm_state_e: controller FSM state encoding
package lstm_pkg;

  localparam int LSTM_DATA_WIDTH  = 16;
  localparam int LSTM_FRACT_WIDTH = 8;

  typedef logic [LSTM_DATA_WIDTH-1:0] lstm_word_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2
  } lstm_state_e;

endpackage

// File: rtl/lstm_seq_ctrl_if.sv
// lstm_seq_ctrl_if: input timestep stream (x_*) and output hidden-state
// stream (h_*) of the LSTM sequence controller.
//   x_valid/x_ready/x_data/x_last : timestep stream, x_last ends a sequence
//   h_valid/h_ready/h_data/h_last : hidden-state stream, h_last ends a sequence
// Handshake: a beat transfers on a rising clock edge where valid && ready.
// The source holds data/last stable and keeps valid high until that edge;
// valid never depends on ready.
//   slave  : the controller side
//   master : the producer/consumer side (parent logic or testbench)
interface lstm_seq_ctrl_if
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH = LSTM_DATA_WIDTH
);

  logic                  x_valid;
  logic                  x_ready;
  logic [DATA_WIDTH-1:0] x_data;
  logic                  x_last;
  logic                  h_valid;
  logic                  h_ready;
  logic [DATA_WIDTH-1:0] h_data;
  logic                  h_last;

  modport master (
    output x_valid, x_data, x_last, h_ready,
    input  x_ready, h_valid, h_data, h_last
  );

  modport slave (
    input  x_valid, x_data, x_last, h_ready,
    output x_ready, h_valid, h_data, h_last
  );

endinterface

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: steps an external lstm_cell through a sequence of timesteps,
// holding the recurrent c/h state between steps.
// Ports:
//   clk, rst            : clock, synchronous active-low reset
//   io (slave)          : x timestep stream in, h hidden-state stream out
//   cell_x/c/h          : registered operands to the cell (X, c_in, h_in)
//   cell_c_out/h_out    : cell results, valid CELL_LAT cycles after operands
//   init_c/init_h       : only with LSTM_SEQ_INIT_LOAD_EN; state loaded at
//                         reset and at sequence end instead of zero
//   c_state             : stored cell state
//   step_idx            : index of the step in progress (wraps silently)
//   busy                : FSM not in IDLE
//   dbg_state           : FSM state for observation
// Optional feature macro: LSTM_SEQ_INIT_LOAD_EN.
module lstm_seq_ctrl
  import lstm_pkg::*;
#(
  parameter int DATA_WIDTH  = LSTM_DATA_WIDTH,
  parameter int FRACT_WIDTH = LSTM_FRACT_WIDTH,
  parameter int CELL_LAT    = 0,
  parameter int STEP_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  lstm_seq_ctrl_if.slave        io,
  output logic [DATA_WIDTH-1:0] cell_x,
  output logic [DATA_WIDTH-1:0] cell_c,
  output logic [DATA_WIDTH-1:0] cell_h,
  input  logic [DATA_WIDTH-1:0] cell_c_out,
  input  logic [DATA_WIDTH-1:0] cell_h_out,
`ifdef LSTM_SEQ_INIT_LOAD_EN
  input  logic [DATA_WIDTH-1:0] init_c,
  input  logic [DATA_WIDTH-1:0] init_h,
`endif
  output logic [DATA_WIDTH-1:0] c_state,
  output logic [STEP_W-1:0]     step_idx,
  output logic                  busy,
  output lstm_state_e           dbg_state
);

  if (CELL_LAT < 0 || CELL_LAT > 15) begin : g_bad_cell_lat
    $error("lstm_seq_ctrl: CELL_LAT must be 0..15");
  end
  if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
    $error("lstm_seq_ctrl: FRACT_WIDTH must be below DATA_WIDTH");
  end

  localparam logic [3:0] LAT_MAX = 4'(CELL_LAT);

  // Value the recurrent state returns to at reset and after a sequence.
  logic [DATA_WIDTH-1:0] seq_c, seq_h;
`ifdef LSTM_SEQ_INIT_LOAD_EN
  assign seq_c = init_c;
  assign seq_h = init_h;
`else
  assign seq_c = '0;
  assign seq_h = '0;
`endif

  lstm_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] x_q, x_d;
  logic [DATA_WIDTH-1:0] c_q, c_d;
  logic [DATA_WIDTH-1:0] h_q, h_d;
  logic [DATA_WIDTH-1:0] h_data_q, h_data_d;
  logic [3:0]            lat_cnt_q, lat_cnt_d;
  logic [STEP_W-1:0]     step_q, step_d;
  logic                  last_q, last_d;
  logic                  x_ready_int, h_valid_int;

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    c_d         = c_q;
    h_d         = h_q;
    h_data_d    = h_data_q;
    lat_cnt_d   = lat_cnt_q;
    step_d      = step_q;
    last_d      = last_q;
    x_ready_int = 1'b0;
    h_valid_int = 1'b0;
    case (state_q)
      ST_IDLE: begin
        x_ready_int = 1'b1;
        if (io.x_valid) begin
          x_d       = io.x_data;
          last_d    = io.x_last;
          lat_cnt_d = '0;
          state_d   = ST_COMPUTE;
        end
      end
      ST_COMPUTE: begin
        // Operands have been stable since entry; results are trusted only
        // once lat_cnt reaches the cell latency.
        if (lat_cnt_q == LAT_MAX) begin
          c_d      = cell_c_out;
          h_d      = cell_h_out;
          h_data_d = cell_h_out;
          state_d  = ST_EMIT;
        end else begin
          lat_cnt_d = lat_cnt_q + 4'd1;
        end
      end
      ST_EMIT: begin
        h_valid_int = 1'b1;
        if (io.h_ready) begin
          state_d = ST_IDLE;
          if (last_q) begin
            c_d    = seq_c;
            h_d    = seq_h;
            step_d = '0;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      c_q       <= seq_c;
      h_q       <= seq_h;
      h_data_q  <= '0;
      lat_cnt_q <= '0;
      step_q    <= '0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      c_q       <= c_d;
      h_q       <= h_d;
      h_data_q  <= h_data_d;
      lat_cnt_q <= lat_cnt_d;
      step_q    <= step_d;
      last_q    <= last_d;
    end
  end

  // Handshake outputs are masked while reset is asserted so that no beat
  // can appear to transfer in a reset cycle.
  assign io.x_ready = x_ready_int & rst;
  assign io.h_valid = h_valid_int & rst;
  assign io.h_data  = h_data_q;
  assign io.h_last  = h_valid_int & rst & last_q;

  assign cell_x    = x_q;
  assign cell_c    = c_q;
  assign cell_h    = h_q;
  assign c_state   = c_q;
  assign step_idx  = step_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// Testbench for lstm_seq_ctrl: one instance with CELL_LAT=0 and a
// combinational cell model (c_out=c+x, h_out=x), one with CELL_LAT=3 and the
// same model behind a 3-stage delay line.
module tb_lstm_seq_ctrl;
  import lstm_pkg::*;

  localparam int DW = 16;

`ifdef LSTM_SEQ_INIT_LOAD_EN
  localparam logic [DW-1:0] INIT_C = 16'h0080;
  localparam logic [DW-1:0] INIT_H = 16'h0040;
  logic [DW-1:0] init_c = INIT_C;
  logic [DW-1:0] init_h = INIT_H;
`else
  localparam logic [DW-1:0] INIT_C = 16'h0000;
  localparam logic [DW-1:0] INIT_H = 16'h0000;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- DUT 0: CELL_LAT = 0 ----------------
  lstm_seq_ctrl_if #(.DATA_WIDTH(DW)) if0 ();
  logic [DW-1:0] cx0, cc0, ch0, cco0, cho0, cst0;
  logic [7:0]    step0;
  logic          busy0;
  lstm_state_e   st0;

  assign cco0 = cc0 + cx0;
  assign cho0 = cx0;

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LAT(0), .STEP_W(8)) u0 (
    .clk        (clk),
    .rst        (rst),
    .io         (if0),
    .cell_x     (cx0),
    .cell_c     (cc0),
    .cell_h     (ch0),
    .cell_c_out (cco0),
    .cell_h_out (cho0),
`ifdef LSTM_SEQ_INIT_LOAD_EN
    .init_c     (init_c),
    .init_h     (init_h),
`endif
    .c_state    (cst0),
    .step_idx   (step0),
    .busy       (busy0),
    .dbg_state  (st0)
  );

  // ---------------- DUT 1: CELL_LAT = 3 ----------------
  lstm_seq_ctrl_if #(.DATA_WIDTH(DW)) if1 ();
  logic [DW-1:0] cx1, cc1, ch1, cst1;
  logic [7:0]    step1;
  logic          busy1;
  lstm_state_e   st1;
  logic [2*DW-1:0] pipe1 = '0, pipe2 = '0, pipe3 = '0;

  always @(posedge clk) begin
    pipe1 <= {cc1 + cx1, cx1};
    pipe2 <= pipe1;
    pipe3 <= pipe2;
  end

  lstm_seq_ctrl #(.DATA_WIDTH(DW), .FRACT_WIDTH(8), .CELL_LAT(3), .STEP_W(8)) u1 (
    .clk        (clk),
    .rst        (rst),
    .io         (if1),
    .cell_x     (cx1),
    .cell_c     (cc1),
    .cell_h     (ch1),
    .cell_c_out (pipe3[2*DW-1:DW]),
    .cell_h_out (pipe3[DW-1:0]),
`ifdef LSTM_SEQ_INIT_LOAD_EN
    .init_c     (init_c),
    .init_h     (init_h),
`endif
    .c_state    (cst1),
    .step_idx   (step1),
    .busy       (busy1),
    .dbg_state  (st1)
  );

  // ---------------- driver: one full step on DUT 0 ----------------
  // Called at a negedge with DUT 0 in IDLE. stall = cycles h_ready is held
  // low in EMIT while a second x is offered.
  task automatic run_step0(input logic [DW-1:0] x, input logic last, input int stall,
                           input logic [DW-1:0] exp_c, input logic [7:0] exp_step,
                           input string tag);
    logic [7:0] nxt_step;
    n_checks++; if (if0.x_ready !== 1'b1) begin n_fail++; $display("FAIL %s idle_x_ready got=%0h exp=1", tag, if0.x_ready); end
    if0.x_valid = 1'b1; if0.x_data = x; if0.x_last = last;
    @(negedge clk);
    if0.x_valid = (stall > 0); if0.x_data = 16'hBEEF; if0.x_last = 1'b0;
    n_checks++; if (if0.x_ready !== 1'b0 || busy0 !== 1'b1) begin n_fail++; $display("FAIL %s compute_ctl got x_ready=%0h busy=%0h exp 0/1", tag, if0.x_ready, busy0); end
    n_checks++; if (cx0 !== x) begin n_fail++; $display("FAIL %s cell_x got=%h exp=%h", tag, cx0, x); end
    n_checks++; if (step0 !== exp_step) begin n_fail++; $display("FAIL %s step_idx got=%0d exp=%0d", tag, step0, exp_step); end
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      n_checks++; if (if0.h_valid !== 1'b1 || if0.h_data !== x || if0.h_last !== last) begin n_fail++; $display("FAIL %s stall_hold[%0d] got v=%0h d=%h l=%0h exp v=1 d=%h l=%0h", tag, i, if0.h_valid, if0.h_data, if0.h_last, x, last); end
      n_checks++; if (if0.x_ready !== 1'b0 || cx0 !== x) begin n_fail++; $display("FAIL %s stall_no_accept[%0d] got x_ready=%0h cell_x=%h exp 0/%h", tag, i, if0.x_ready, cx0, x); end
      @(negedge clk);
    end
    n_checks++; if (if0.h_valid !== 1'b1 || if0.x_ready !== 1'b0) begin n_fail++; $display("FAIL %s emit_ctl got h_valid=%0h x_ready=%0h exp 1/0", tag, if0.h_valid, if0.x_ready); end
    n_checks++; if (if0.h_data !== x) begin n_fail++; $display("FAIL %s h_data got=%h exp=%h", tag, if0.h_data, x); end
    n_checks++; if (if0.h_last !== last) begin n_fail++; $display("FAIL %s h_last got=%0h exp=%0h", tag, if0.h_last, last); end
    n_checks++; if (cst0 !== exp_c) begin n_fail++; $display("FAIL %s c_state_emit got=%h exp=%h", tag, cst0, exp_c); end
    if0.h_ready = 1'b1; if0.x_valid = 1'b0;
    @(negedge clk);
    if0.h_ready = 1'b0;
    nxt_step = last ? 8'd0 : 8'(exp_step + 8'd1);
    n_checks++; if (if0.h_valid !== 1'b0 || if0.x_ready !== 1'b1) begin n_fail++; $display("FAIL %s back_idle got h_valid=%0h x_ready=%0h exp 0/1", tag, if0.h_valid, if0.x_ready); end
    n_checks++; if (cst0 !== (last ? INIT_C : exp_c)) begin n_fail++; $display("FAIL %s c_state_after got=%h exp=%h", tag, cst0, last ? INIT_C : exp_c); end
    n_checks++; if (step0 !== nxt_step) begin n_fail++; $display("FAIL %s step_after got=%0d exp=%0d", tag, step0, nxt_step); end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (if0.x_ready !== 1'b0 || if0.h_valid !== 1'b0) begin n_fail++; $display("FAIL reset_handshake got x_ready=%0h h_valid=%0h exp 0/0", if0.x_ready, if0.h_valid); end
    n_checks++; if (busy0 !== 1'b0 || step0 !== 8'd0) begin n_fail++; $display("FAIL reset_busy_step got busy=%0h step=%0d exp 0/0", busy0, step0); end
    n_checks++; if (cst0 !== INIT_C || ch0 !== INIT_H) begin n_fail++; $display("FAIL reset_state got c=%h h=%h exp %h/%h", cst0, ch0, INIT_C, INIT_H); end
    n_checks++; if (cx0 !== 16'h0 || if0.h_data !== 16'h0) begin n_fail++; $display("FAIL reset_regs got x=%h h_data=%h exp 0/0", cx0, if0.h_data); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if0.x_ready !== 1'b1 || if1.x_ready !== 1'b1) begin n_fail++; $display("FAIL release_x_ready got %0h/%0h exp 1/1", if0.x_ready, if1.x_ready); end
  endtask

  task automatic test_sequence();
    run_step0(16'h0100, 1'b0, 0, INIT_C + 16'h0100, 8'd0, "seq0");
    run_step0(16'h0200, 1'b0, 0, INIT_C + 16'h0300, 8'd1, "seq1");
    run_step0(16'h0300, 1'b1, 0, INIT_C + 16'h0600, 8'd2, "seq2");
  endtask

  task automatic test_stall();
    run_step0(16'h0700, 1'b1, 5, INIT_C + 16'h0700, 8'd0, "stall");
  endtask

  task automatic test_reset_mid();
    if0.x_valid = 1'b1; if0.x_data = 16'h0900; if0.x_last = 1'b0;
    @(negedge clk);
    if0.x_valid = 1'b0;
    n_checks++; if (busy0 !== 1'b1) begin n_fail++; $display("FAIL midrst_in_compute got busy=%0h exp 1", busy0); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (busy0 !== 1'b0 || if0.h_valid !== 1'b0 || if0.x_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ctl got busy=%0h h_valid=%0h x_ready=%0h exp 0/0/0", busy0, if0.h_valid, if0.x_ready); end
    n_checks++; if (cx0 !== 16'h0 || cst0 !== INIT_C || step0 !== 8'd0 || if0.h_data !== 16'h0) begin n_fail++; $display("FAIL midrst_regs got x=%h c=%h step=%0d h_data=%h", cx0, cst0, step0, if0.h_data); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (if0.h_valid !== 1'b0 || busy0 !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit got h_valid=%0h busy=%0h exp 0/0", if0.h_valid, busy0); end
    run_step0(16'h0500, 1'b1, 0, INIT_C + 16'h0500, 8'd0, "post_rst");
  endtask

  task automatic test_wrap();
    logic [DW-1:0] c_exp;
    logic [DW-1:0] x;
    c_exp = INIT_C;
    for (int k = 0; k < 300; k++) begin
      x = 16'(k % 200) + 16'h0011;
      c_exp = c_exp + x;
      run_step0(x, 1'b0, 0, c_exp, 8'(k), "wrap");
    end
    n_checks++; if (step0 !== 8'd44) begin n_fail++; $display("FAIL wrap_final_step got=%0d exp=44", step0); end
    run_step0(16'h0001, 1'b1, 0, c_exp + 16'h0001, 8'd44, "wrap_last");
  endtask

  task automatic test_latency();
    // First step: h_valid must rise exactly 4 cycles after the accept edge.
    n_checks++; if (if1.x_ready !== 1'b1) begin n_fail++; $display("FAIL lat_idle got x_ready=%0h exp 1", if1.x_ready); end
    if1.x_valid = 1'b1; if1.x_data = 16'h0A00; if1.x_last = 1'b0;
    @(negedge clk);
    if1.x_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (if1.h_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid[%0d] got=%0h exp=0", i, if1.h_valid); end
      @(negedge clk);
    end
    n_checks++; if (if1.h_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid_rise got=%0h exp=1", if1.h_valid); end
    n_checks++; if (if1.h_data !== 16'h0A00 || cst1 !== INIT_C + 16'h0A00) begin n_fail++; $display("FAIL lat_step0 got h=%h c=%h exp %h/%h", if1.h_data, cst1, 16'h0A00, INIT_C + 16'h0A00); end
    if1.h_ready = 1'b1;
    @(negedge clk);
    if1.h_ready = 1'b0;
    // Second step: an early sample would still show the previous operands.
    if1.x_valid = 1'b1; if1.x_data = 16'h0B00; if1.x_last = 1'b1;
    @(negedge clk);
    if1.x_valid = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++; if (if1.h_valid !== 1'b1 || if1.h_last !== 1'b1) begin n_fail++; $display("FAIL lat_step1_ctl got v=%0h l=%0h exp 1/1", if1.h_valid, if1.h_last); end
    n_checks++; if (if1.h_data !== 16'h0B00 || cst1 !== INIT_C + 16'h1500) begin n_fail++; $display("FAIL lat_step1 got h=%h c=%h exp %h/%h", if1.h_data, cst1, 16'h0B00, INIT_C + 16'h1500); end
    if1.h_ready = 1'b1;
    @(negedge clk);
    if1.h_ready = 1'b0;
    n_checks++; if (cst1 !== INIT_C || step1 !== 8'd0 || if1.x_ready !== 1'b1) begin n_fail++; $display("FAIL lat_seq_end got c=%h step=%0d x_ready=%0h exp %h/0/1", cst1, step1, if1.x_ready, INIT_C); end
  endtask

  // ---------------- main ----------------
  initial begin
    if0.x_valid = 1'b0; if0.x_data = '0; if0.x_last = 1'b0; if0.h_ready = 1'b0;
    if1.x_valid = 1'b0; if1.x_data = '0; if1.x_last = 1'b0; if1.h_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_sequence();
    test_stall();
    test_reset_mid();
    test_wrap();
    test_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
